up_counter_ctl: RTL

Loadable 6-bit up counter: the incrementing counterpart of the team's down counter, for timers and sequence indices that count toward a terminal value.
- Counts from 0, or from a loaded value, up to a programmable `limit`.
- Either wraps to 0 or saturates at `limit`, selected by `mode_sat`.
- Flags a wrap with a one-cycle pulse and records any overflow in a sticky flag.
- Optionally advances only on ticks from an internal prescaler.

---
 rtl/up_counter_pkg.sv | 18 +
 rtl/up_counter_prescaler.sv | 45 ++++
 rtl/up_counter_ctl.sv | 112 +++++++++++
 3 files changed

// File: rtl/up_counter_pkg.sv
// Shared types and constants for the loadable up counter.
//   UPC_WIDTH      : default count/load/limit width
//   UPC_PRESCALE_W : default prescaler divisor width
//   upc_mode_e     : terminal-count behaviour (wrap to 0 or saturate at limit)
//   upc_count_t    : count value at the default width
package up_counter_pkg;

  localparam int unsigned UPC_WIDTH      = 6;
  localparam int unsigned UPC_PRESCALE_W = 4;

  typedef enum logic {
    UPC_MODE_WRAP = 1'b0,
    UPC_MODE_SAT  = 1'b1
  } upc_mode_e;

  typedef logic [UPC_WIDTH-1:0] upc_count_t;

endpackage

// File: rtl/up_counter_prescaler.sv
// Tick generator for up_counter_ctl. Counts enabled cycles and emits a one-cycle
// tick when the internal count equals prescale, then restarts from 0.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   clr      : restarts the phase at 0 (driven by the counter's load)
//   en       : count enable; the phase holds while low
//   prescale : divisor minus 1 (0 = tick on every enabled cycle)
//   tick     : combinational tick, valid in the cycle the compare matches
module up_counter_prescaler
  import up_counter_pkg::*;
#(
  parameter int unsigned PRESCALE_W = UPC_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = en && (pcnt_q == prescale);
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (en) begin
      // If prescale shrank below the phase, this rolls over and matches on the way round.
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/up_counter_ctl.sv
// Loadable up counter with programmable terminal value, wrap/saturate modes,
// a one-cycle wrap pulse and a sticky overflow flag. All outputs are registered.
// Optional feature: define UP_COUNTER_PRESCALE_EN to advance only on prescaler ticks.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   en       : count enable
//   load     : load load_val (beats advance)
//   load_val : value to load
//   limit    : terminal count value
//   mode_sat : 0 = wrap to 0, 1 = saturate at limit
//   clr_ovf  : clears ovf (a simultaneous overflow wins)
//   prescale : tick divisor minus 1, unused without the macro
//   count    : current count
//   wrap     : pulse in the cycle count first reads 0 after a wrap
//   ovf      : sticky overflow flag
module up_counter_ctl
  import up_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = UPC_WIDTH,
  parameter int unsigned PRESCALE_W = UPC_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  mode_sat,
  input  logic                  clr_ovf,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  wrap,
  output logic                  ovf
);

  logic tick;

`ifdef UP_COUNTER_PRESCALE_EN
  up_counter_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (load),
    .en       (en),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick            = 1'b1;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             advance;
  logic             at_limit;
  logic             ovf_set;
  upc_mode_e        mode;

  assign mode     = upc_mode_e'(mode_sat);
  assign advance  = en && tick;
  // >= rather than == so a loaded value above limit still terminates.
  assign at_limit = (count_q >= limit);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (advance) begin
      if (at_limit) begin
        ovf_set = 1'b1;
        if (mode == UPC_MODE_SAT) begin
          count_d = limit;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule
